// File: rtl/ui_mul_seq.sv
// ui_mul_seq: sequential unsigned shift-and-add multiplier.
// One partial product is accumulated per clock while BUSY; the result is
// held in y_b with end_step high in DONE until start is released.
// Optional build macro: UI_MUL_SEQ_EARLY_EXIT_EN lets BUSY finish as soon
// as no set multiplier bits remain, instead of always taking WIDTH cycles.
module ui_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_b,
  input  logic [WIDTH-1:0]     b_b,
  output logic [2*WIDTH-1:0]   y_b,
  output logic                 end_step,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT               state;
  stateT               stateNext;
  logic [2*WIDTH-1:0]  multiplicand;
  logic [WIDTH-1:0]    multiplier;
  logic [CW-1:0]       stepCount;
  logic                lastStep;

  // Decide whether the current BUSY edge is the final accumulation step.
`ifdef UI_MUL_SEQ_EARLY_EXIT_EN
  always_comb begin
    lastStep = (stepCount == LAST_COUNT) || ((multiplier >> 1) == '0);
  end
`else
  always_comb begin
    lastStep = (stepCount == LAST_COUNT);
  end
`endif

  // State register; reset returns to IDLE and abandons any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; DONE waits for start to drop so a held request
  // cannot launch a second multiplication.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start)    stateNext = BUSY;
      BUSY:    if (lastStep) stateNext = DONE;
      DONE:    if (!start)   stateNext = IDLE;
      default:               stateNext = IDLE;
    endcase
  end

  // Datapath: capture operands in IDLE, add-and-shift while BUSY, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_b          <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
      stepCount    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            multiplicand <= {{WIDTH{1'b0}}, a_b};
            multiplier   <= b_b;
            y_b          <= '0;
            stepCount    <= '0;
          end
        end
        BUSY: begin
          if (multiplier[0]) begin
            y_b <= y_b + multiplicand;
          end
          multiplicand <= multiplicand << 1;
          multiplier   <= multiplier >> 1;
          stepCount    <= stepCount + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs come straight from the state register.
  always_comb begin
    end_step = (state == DONE);
    busy     = (state == BUSY);
  end

endmodule

// File: tb/tb_ui_mul_seq.sv
// tb_ui_mul_seq: directed self-checking bench for ui_mul_seq (WIDTH=32).
// Expected products and latencies are queued when an operation is launched
// and popped when the DUT signals completion.
module tb_ui_mul_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   aB;
  logic [W-1:0]   bB;
  logic [2*W-1:0] yB;
  logic           endStep;
  logic           busy;

  int vectorCount = 0;
  int missCount   = 0;

  logic [63:0] expQ[$];
  int          latQ[$];

  ui_mul_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_b      (aB),
    .b_b      (bB),
    .y_b      (yB),
    .end_step (endStep),
    .busy     (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Expected cycles from capture edge to end_step.
  function automatic int expLatency(input logic [31:0] b);
    int lat;
    lat = W;
`ifdef UI_MUL_SEQ_EARLY_EXIT_EN
    lat = 1;
    for (int i = 0; i < W; i++) begin
      if (b[i]) lat = i + 1;
    end
`endif
    return lat;
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectorCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch an operation from IDLE; returns one time unit after the capture edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit hold);
    aB    = a;
    bB    = b;
    start = 1'b1;
    expQ.push_back(64'(a) * 64'(b));
    latQ.push_back(expLatency(b));
    step();
    if (!hold) start = 1'b0;
  endtask

  // Wait (bounded) for end_step and check latency and BUSY duration.
  task automatic waitDone(input string tag);
    int cycles;
    int busyCycles;
    int expLat;
    cycles     = 0;
    busyCycles = 0;
    expLat     = (latQ.size() > 0) ? latQ.pop_front() : -1;
    while (!endStep && cycles < 100) begin
      if (busy) busyCycles++;
      step();
      cycles++;
    end
    checkValue({tag, " latency"}, 64'(cycles), 64'(expLat));
    checkValue({tag, " busy cycles"}, 64'(busyCycles), 64'(expLat));
  endtask

  // Compare the finished product against the scoreboard head.
  task automatic checkOutput(input string tag);
    logic [63:0] exp;
    checkValue({tag, " pending"}, 64'(expQ.size()), 64'd1);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 64'hx;
    checkValue({tag, " product"}, yB, exp);
    checkValue({tag, " end_step"}, 64'(endStep), 64'd1);
  endtask

  // Release start and confirm the return to IDLE one edge later.
  task automatic finishOp(input string tag);
    start = 1'b0;
    step();
    checkValue({tag, " end_step drop"}, 64'(endStep), 64'd0);
    checkValue({tag, " busy idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    rst   = 1'b1;
    start = 1'b0;
    aB    = '0;
    bB    = '0;
    step();
    step();
    checkValue("reset y_b", yB, 64'd0);
    checkValue("reset end_step", 64'(endStep), 64'd0);
    checkValue("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;

    $display("[TB] basic product, start held");
    applyStimulus(32'd3, 32'd5, 1'b1);
    waitDone("basic");
    checkOutput("basic");
    finishOp("basic");

    $display("[TB] maximum operands, single-cycle start");
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    waitDone("max");
    checkValue("max literal", yB, 64'hFFFF_FFFE_0000_0001);
    checkOutput("max");
    step();
    checkValue("max one-cycle end_step", 64'(endStep), 64'd0);

    $display("[TB] held start in DONE");
    applyStimulus(32'd12, 32'd13, 1'b1);
    waitDone("held");
    checkOutput("held");
    for (int i = 0; i < 5; i++) begin
      step();
      checkValue("held stays done", 64'(endStep), 64'd1);
      checkValue("held y_b stable", yB, 64'd156);
    end
    finishOp("held");
    repeat (3) step();
    checkValue("held no retrigger", 64'(busy), 64'd0);

    $display("[TB] reset mid-operation");
    aB    = 32'd7;
    bB    = 32'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    checkValue("abort busy before", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    checkValue("abort busy", 64'(busy), 64'd0);
    checkValue("abort end_step", 64'(endStep), 64'd0);
    checkValue("abort y_b", yB, 64'd0);
    aB    = 32'd5;
    bB    = 32'd5;
    start = 1'b1;
    step();
    checkValue("rst priority busy", 64'(busy), 64'd0);
    checkValue("rst priority y_b", yB, 64'd0);
    rst = 1'b0;
    applyStimulus(32'd2, 32'd4, 1'b0);
    checkValue("first start accepted", 64'(busy), 64'd1);
    waitDone("after abort");
    checkOutput("after abort");
    finishOp("after abort");

    $display("[TB] latency corner operands");
    applyStimulus(32'h1234, 32'd1, 1'b0);
    waitDone("b=1");
    checkOutput("b=1");
    finishOp("b=1");
    applyStimulus(32'd3, 32'h8000_0000, 1'b0);
    waitDone("b=msb");
    checkOutput("b=msb");
    finishOp("b=msb");
    applyStimulus(32'hDEAD_BEEF, 32'd0, 1'b0);
    waitDone("b=0");
    checkOutput("b=0");
    finishOp("b=0");

    $display("[TB] operand change after capture");
    applyStimulus(32'd6, 32'd7, 1'b0);
    aB = 32'hFF;
    bB = 32'hFF;
    waitDone("late change");
    checkOutput("late change");
    finishOp("late change");

    $display("[TB] random operands");
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      applyStimulus(ra, rb, 1'b0);
      waitDone("random");
      checkOutput("random");
      finishOp("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
